// File: rtl/reg_value_forward.sv
// Single-source operand bypass selector: substitutes the first-priority writer's data when it targets
// the requested (non-zero) register; a small clocked monitor tracks the forward flag and a hit counter.
module reg_value_forward #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [REG_W-1:0]  ReadRegister1,
    input  logic [DATA_W-1:0] RegisterData1,
    input  logic [REG_W-1:0]  WriteRegister1stPri1,
    input  logic [DATA_W-1:0] WriteData1stPri1,
    input  logic              Valid1stPri1,
    input  logic              comment,
    output logic [DATA_W-1:0] Output1,
    output logic              Forwarded,
    output logic              Forwarded_q,
    output logic [CNT_W-1:0]  HitCount
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic hit;

    // The trace enable only steers simulation printing, which has no place in synthesizable logic.
    logic unused_comment;
    assign unused_comment = comment;

    // Register $0 is hardwired to zero, so a writer naming it must never be bypassed.
    always_comb begin
        hit = Valid1stPri1
              && (WriteRegister1stPri1 == ReadRegister1)
              && (ReadRegister1 != '0);
    end

    assign Output1   = hit ? WriteData1stPri1 : RegisterData1;
    assign Forwarded = hit;

    // Monitor only; the counter saturates rather than wrapping so long runs stay meaningful.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            Forwarded_q <= 1'b0;
            HitCount    <= '0;
        end else begin
            Forwarded_q <= hit;
            if (hit && (HitCount != CNT_MAX)) begin
                HitCount <= HitCount + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_reg_value_forward.sv
// Self-checking bench for reg_value_forward: directed scenarios plus randomized traffic against a
// rule-level model; a second instance with a 4-bit counter exercises saturation.
module tb_reg_value_forward;

    localparam int DATA_W = 32;
    localparam int REG_W  = 5;

    logic              CLK;
    logic              RESET;
    logic [REG_W-1:0]  ReadRegister1;
    logic [DATA_W-1:0] RegisterData1;
    logic [REG_W-1:0]  WriteRegister1stPri1;
    logic [DATA_W-1:0] WriteData1stPri1;
    logic              Valid1stPri1;
    logic              comment;

    logic [DATA_W-1:0] Output1,   Output1_s;
    logic              Forwarded, Forwarded_s;
    logic              Forwarded_q, Forwarded_q_s;
    logic [15:0]       HitCount;
    logic [3:0]        HitCount_s;

    int vectors = 0;
    int errors  = 0;

    // Reference model state
    int m_cnt16 = 0;
    int m_cnt4  = 0;
    bit m_fq    = 0;

    reg_value_forward #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(16)) dut (
        .CLK(CLK), .RESET(RESET),
        .ReadRegister1(ReadRegister1), .RegisterData1(RegisterData1),
        .WriteRegister1stPri1(WriteRegister1stPri1), .WriteData1stPri1(WriteData1stPri1),
        .Valid1stPri1(Valid1stPri1), .comment(comment),
        .Output1(Output1), .Forwarded(Forwarded),
        .Forwarded_q(Forwarded_q), .HitCount(HitCount)
    );

    reg_value_forward #(.DATA_W(DATA_W), .REG_W(REG_W), .CNT_W(4)) dut_sat (
        .CLK(CLK), .RESET(RESET),
        .ReadRegister1(ReadRegister1), .RegisterData1(RegisterData1),
        .WriteRegister1stPri1(WriteRegister1stPri1), .WriteData1stPri1(WriteData1stPri1),
        .Valid1stPri1(Valid1stPri1), .comment(comment),
        .Output1(Output1_s), .Forwarded(Forwarded_s),
        .Forwarded_q(Forwarded_q_s), .HitCount(HitCount_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic bit model_hit();
        return Valid1stPri1 && (WriteRegister1stPri1 == ReadRegister1) && (ReadRegister1 != 0);
    endfunction

    function automatic logic [DATA_W-1:0] model_out();
        return model_hit() ? WriteData1stPri1 : RegisterData1;
    endfunction

    task automatic drive(input logic [REG_W-1:0] rd, input logic [DATA_W-1:0] rdata,
                         input logic [REG_W-1:0] wr, input logic [DATA_W-1:0] wdata,
                         input logic v);
        ReadRegister1        = rd;
        RegisterData1        = rdata;
        WriteRegister1stPri1 = wr;
        WriteData1stPri1     = wdata;
        Valid1stPri1         = v;
        #1;
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge, settle after it.
    task automatic tick();
        @(posedge CLK);
        if (RESET) begin
            m_fq = model_hit();
            if (m_fq && m_cnt16 < 65535) m_cnt16++;
            if (m_fq && m_cnt4 < 15)     m_cnt4++;
        end
        #2;
    endtask

    task automatic test_reset();
        RESET = 1'b0;
        comment = 1'b0;
        drive(5'd3, 32'hAAAA0000, 5'd3, 32'h5555FFFF, 1'b1);
        vectors++;
        if (Forwarded_q !== 1'b0 || HitCount !== 16'd0) begin
            errors++;
            $display("[TB] FAIL reset_state: Forwarded_q=%b HitCount=%0d, expected 0/0", Forwarded_q, HitCount);
        end
        vectors++;
        if (Output1 !== 32'h5555FFFF || Forwarded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL comb_in_reset: Output1=%h Forwarded=%b, expected 5555ffff/1", Output1, Forwarded);
        end
        tick();
        vectors++;
        if (HitCount !== 16'd0 || Forwarded_q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_hold: HitCount=%0d Forwarded_q=%b, expected 0/0", HitCount, Forwarded_q);
        end
        RESET = 1'b1;
        m_cnt16 = 0; m_cnt4 = 0; m_fq = 0;
    endtask

    task automatic test_basic_forward();
        drive(5'd5, 32'h11111111, 5'd5, 32'hDEADBEEF, 1'b1);
        vectors++;
        if (Output1 !== 32'hDEADBEEF || Forwarded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL basic_fwd_comb: Output1=%h Forwarded=%b, expected deadbeef/1", Output1, Forwarded);
        end
        tick();
        vectors++;
        if (Forwarded_q !== 1'b1 || HitCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL basic_fwd_reg: Forwarded_q=%b HitCount=%0d, expected 1/1", Forwarded_q, HitCount);
        end
    endtask

    task automatic test_mismatch();
        drive(5'd5, 32'h11111111, 5'd6, 32'hDEADBEEF, 1'b1);
        vectors++;
        if (Output1 !== 32'h11111111 || Forwarded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL mismatch_comb: Output1=%h Forwarded=%b, expected 11111111/0", Output1, Forwarded);
        end
        tick();
        vectors++;
        if (Forwarded_q !== 1'b0 || HitCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL mismatch_reg: Forwarded_q=%b HitCount=%0d, expected 0/1", Forwarded_q, HitCount);
        end
    endtask

    task automatic test_invalid_writer();
        drive(5'd7, 32'hCAFEDEAD, 5'd7, 32'h12345678, 1'b0);
        vectors++;
        if (Output1 !== 32'hCAFEDEAD || Forwarded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL invalid_writer: Output1=%h Forwarded=%b, expected cafedead/0", Output1, Forwarded);
        end
        tick();
        vectors++;
        if (HitCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL invalid_count: HitCount=%0d, expected 1", HitCount);
        end
    endtask

    task automatic test_register_zero();
        drive(5'd0, 32'h00000000, 5'd0, 32'hFFFFFFFF, 1'b1);
        vectors++;
        if (Output1 !== 32'h00000000 || Forwarded !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reg_zero: Output1=%h Forwarded=%b, expected 00000000/0", Output1, Forwarded);
        end
        tick();
        vectors++;
        if (Forwarded_q !== 1'b0 || HitCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL reg_zero_reg: Forwarded_q=%b HitCount=%0d, expected 0/1", Forwarded_q, HitCount);
        end
    endtask

    task automatic test_reset_midrun();
        RESET = 1'b0; #1; RESET = 1'b1;
        m_cnt16 = 0; m_cnt4 = 0; m_fq = 0;
        drive(5'd9, 32'h0, 5'd9, 32'h99990000, 1'b1);
        for (int i = 0; i < 3; i++) tick();
        vectors++;
        if (HitCount !== 16'd3 || Forwarded_q !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_pre: HitCount=%0d Forwarded_q=%b, expected 3/1", HitCount, Forwarded_q);
        end
        RESET = 1'b0;
        #1;
        m_cnt16 = 0; m_cnt4 = 0; m_fq = 0;
        vectors++;
        if (HitCount !== 16'd0 || Forwarded_q !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrun_clear: HitCount=%0d Forwarded_q=%b, expected 0/0", HitCount, Forwarded_q);
        end
        drive(5'd9, 32'h0, 5'd9, 32'h77770000, 1'b1);
        vectors++;
        if (Output1 !== 32'h77770000 || Forwarded !== 1'b1) begin
            errors++;
            $display("[TB] FAIL midrun_comb: Output1=%h Forwarded=%b, expected 77770000/1", Output1, Forwarded);
        end
        @(negedge CLK);
        RESET = 1'b1;
        tick();
        vectors++;
        if (HitCount !== 16'd1) begin
            errors++;
            $display("[TB] FAIL midrun_release: HitCount=%0d, expected 1", HitCount);
        end
    endtask

    task automatic test_saturation();
        RESET = 1'b0; #1; RESET = 1'b1;
        m_cnt16 = 0; m_cnt4 = 0; m_fq = 0;
        drive(5'd31, 32'h1, 5'd31, 32'h2, 1'b1);
        for (int i = 0; i < 20; i++) tick();
        vectors++;
        if (HitCount_s !== 4'd15 || HitCount !== 16'd20) begin
            errors++;
            $display("[TB] FAIL saturate: HitCount_s=%0d HitCount=%0d, expected 15/20", HitCount_s, HitCount);
        end
        tick();
        vectors++;
        if (HitCount_s !== 4'd15) begin
            errors++;
            $display("[TB] FAIL saturate_hold: HitCount_s=%0d, expected 15", HitCount_s);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            comment = 1'($urandom_range(0, 1));
            drive(5'($urandom_range(0, 7)), $urandom, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 3) != 0));
            vectors++;
            if (Output1 !== model_out() || Forwarded !== model_hit()) begin
                errors++;
                $display("[TB] FAIL rand_comb[%0d]: Output1=%h Forwarded=%b, expected %h/%b",
                         i, Output1, Forwarded, model_out(), model_hit());
            end
            tick();
            vectors++;
            if (Forwarded_q !== m_fq || HitCount !== 16'(m_cnt16) || HitCount_s !== 4'(m_cnt4)) begin
                errors++;
                $display("[TB] FAIL rand_reg[%0d]: Forwarded_q=%b HitCount=%0d HitCount_s=%0d, expected %b/%0d/%0d",
                         i, Forwarded_q, HitCount, HitCount_s, m_fq, m_cnt16, m_cnt4);
            end
        end
    endtask

    // Trace line the debug enable asks for; kept in the bench since the RTL is print-free.
    always @(posedge CLK) begin
        if (comment && RESET)
            $display("[TB] trace rd=%0d hit=%b out=%h", ReadRegister1, Forwarded, Output1);
    end

    initial begin
        test_reset();
        @(negedge CLK);
        test_basic_forward();
        test_mismatch();
        test_invalid_writer();
        test_register_zero();
        test_reset_midrun();
        test_saturation();
        RESET = 1'b0; #1; RESET = 1'b1;
        m_cnt16 = 0; m_cnt4 = 0; m_fq = 0;
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/reg_value_forward.md
Name: reg_value_forward

Overview:
Single-source operand forwarding (bypass) selector for the MIPS pipeline. It takes a register number and the value read for it from an earlier stage. If the highest-priority in-flight writer targets the same register, it substitutes that writer's data. Used in MEM to recover up-to-date store data when HAS_FORWARDING is defined; the output is combinational. A small registered monitor (forward flag and hit counter) is clocked by CLK.

Parameters:
DATA_W, 32, width of register data
REG_W, 5, width of register index
CNT_W, 16, width of forwarding-hit counter

Ports:
CLK  input  1  clock; rising edge updates monitor registers only
RESET  input  1  asynchronous, active-low reset; clock CLK
ReadRegister1  input  REG_W  register whose value is requested
RegisterData1  input  DATA_W  value read for ReadRegister1 from the register file or pipeline latch
WriteRegister1stPri1  input  REG_W  destination register of the first-priority (youngest completed) writer
WriteData1stPri1  input  DATA_W  data that writer will commit
Valid1stPri1  input  1  writer actually writes a register this cycle
comment  input  1  debug enable; 1 = print a trace line each forwarding decision at posedge
Output1  output  DATA_W  resolved operand value (combinational)
Forwarded  output  1  combinational: 1 when Output1 came from WriteData1stPri1
Forwarded_q  output  1  Forwarded registered at posedge CLK
HitCount  output  CNT_W  count of cycles with Forwarded=1

Behaviour:
- hit = Valid1stPri1 && (WriteRegister1stPri1 == ReadRegister1) && (ReadRegister1 != 0).
- Output1 = hit ? WriteData1stPri1 : RegisterData1. Pure combinational, zero latency, no clock dependency.
- Register 0 is never forwarded. A read of $0 always returns RegisterData1, even if a valid writer names register 0.
- Valid1stPri1=0 means no forwarding, regardless of register match.
- Forwarded = hit.
- Output1 and Forwarded are independent of RESET. They are valid during reset.
- While RESET=0: Forwarded_q=0 and HitCount=0, asynchronously.
- At each posedge CLK with RESET=1: Forwarded_q <= hit.
- At each posedge CLK with RESET=1: HitCount <= HitCount+1 if hit, saturating at all-ones (no wrap).
- Reset asserted mid-operation clears the monitor immediately. The combinational path keeps operating.
- Debug print when comment=1 and RESET=1 at a posedge: simulation-only display of ReadRegister1, hit, Output1. comment has no effect on any signal value.
- All inputs and outputs are X-free after reset when inputs are driven.
- No internal storage affects Output1.

Test Plan:
- Basic forward: RESET=1, Read=5, RegData=0x11111111, WrReg=5, WrData=0xDEADBEEF, Valid=1 -> Output1=0xDEADBEEF, Forwarded=1; next posedge Forwarded_q=1, HitCount=1.
- Mismatch: Read=5, WrReg=6, Valid=1, RegData=0x11111111 -> Output1=0x11111111, Forwarded=0; HitCount unchanged.
- Invalid writer: Read=7, WrReg=7, Valid=0, RegData=0xCAFEDEAD, WrData=0x12345678 -> Output1=0xCAFEDEAD.
- Register zero: Read=0, WrReg=0, Valid=1, RegData=0x00000000, WrData=0xFFFFFFFF -> Output1=0x00000000, Forwarded=0.
- Reset mid-run: after 3 hit cycles (HitCount=3), drop RESET between edges -> HitCount=0 and Forwarded_q=0 immediately; Output1 still follows the hit rule; release, 1 hit cycle -> HitCount=1.
- Saturation: with CNT_W=4, hold a hit for 20 cycles -> HitCount=15 and stays at 15.
